// File: rtl/parity_frame_arbiter_if.sv
// Bus between two serial requesters, the parity arbiter and the downstream result consumer.
// result_valid/result_ready: a result transfers on an edge where both are high; until then the
// arbiter holds result_valid, parity_err and result_src stable and never withdraws result_valid.
interface parity_frame_arbiter_if;
   logic [1:0] req;
   logic [1:0] x;
   logic [1:0] gnt;
   logic       busy;
   logic       result_valid;
   logic       result_ready;
   logic       parity_err;
   logic       result_src;
   logic       abort;
   logic [7:0] err_cnt;

   modport master (
      output req, x, result_ready,
      input  gnt, busy, result_valid, parity_err, result_src, abort, err_cnt
   );

   modport slave (
      input  req, x, result_ready,
      output gnt, busy, result_valid, parity_err, result_src, abort, err_cnt
   );
endinterface

// File: rtl/parity_frame_arbiter.sv
// Round-robin arbiter giving two serial requesters turns on one parity checker; each frame is
// DATA_BITS data bits plus a parity bit, and the pass/fail result leaves on a valid/ready handshake.
module parity_frame_arbiter #(
   parameter int DATA_BITS  = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   parity_frame_arbiter_if.slave bus
);

   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [1:0]    gnt_q, gnt_n;
   logic          sel_q, sel_n;
   logic          last_src, last_src_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          acc, acc_n;
   logic          rv_q, rv_n;
   logic          perr_q, perr_n;
   logic          rsrc_q, rsrc_n;
   logic          abort_q, abort_n;
   logic [7:0]    err_cnt_q, err_cnt_n;
   logic          pick;
   logic          bit_in;

   // The lane that did not go last has priority; otherwise whichever lane is asking.
   assign pick   = bus.req[~last_src] ? ~last_src : last_src;
   assign bit_in = bus.x[sel_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      gnt_n      = gnt_q;
      sel_n      = sel_q;
      last_src_n = last_src;
      cnt_n      = cnt;
      acc_n      = acc;
      rv_n       = rv_q;
      perr_n     = perr_q;
      rsrc_n     = rsrc_q;
      abort_n    = 1'b0;
      err_cnt_n  = err_cnt_q;

      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               sel_n        = pick;
               gnt_n        = 2'b00;
               gnt_n[pick]  = 1'b1;
               cnt_n        = '0;
               acc_n        = 1'b0;
               state_n      = RECV;
            end
         end

         RECV: begin
            if (!bus.req[sel_q]) begin
               // Requester gave up mid-frame: drop the bit on this edge and hand the turn over.
               gnt_n      = 2'b00;
               abort_n    = 1'b1;
               last_src_n = sel_q;
               state_n    = IDLE;
            end else begin
               acc_n = acc ^ bit_in;
               if (cnt == LAST) begin
                  gnt_n   = 2'b00;
                  rv_n    = 1'b1;
                  rsrc_n  = sel_q;
                  perr_n  = acc ^ bit_in ^ ODD_PARITY;
                  state_n = RESULT;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end

         RESULT: begin
            if (rv_q && bus.result_ready) begin
               rv_n       = 1'b0;
               last_src_n = rsrc_q;
               if (perr_q && (err_cnt_q != 8'hFF)) begin
                  err_cnt_n = err_cnt_q + 8'd1;
               end
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            gnt_n   = 2'b00;
            rv_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= 2'b00;
         sel_q     <= 1'b0;
         last_src  <= 1'b1;
         cnt       <= '0;
         acc       <= 1'b0;
         rv_q      <= 1'b0;
         perr_q    <= 1'b0;
         rsrc_q    <= 1'b0;
         abort_q   <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         gnt_q     <= gnt_n;
         sel_q     <= sel_n;
         last_src  <= last_src_n;
         cnt       <= cnt_n;
         acc       <= acc_n;
         rv_q      <= rv_n;
         perr_q    <= perr_n;
         rsrc_q    <= rsrc_n;
         abort_q   <= abort_n;
         err_cnt_q <= err_cnt_n;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.busy         = (state != IDLE);
   assign bus.result_valid = rv_q;
   assign bus.parity_err   = perr_q;
   assign bus.result_src   = rsrc_q;
   assign bus.abort        = abort_q;
   assign bus.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Directed bench for parity_frame_arbiter: reset, parity pass/fail, saturation, alternation,
// result back-pressure and mid-frame abort, each with hand-computed expectations.
module tb_parity_frame_arbiter;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   parity_frame_arbiter_if bus ();

   parity_frame_arbiter #(
      .DATA_BITS  (8),
      .ODD_PARITY (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Drives n serial bits on lane (bit i of bits goes out i-th); the idle lane gets inverted noise.
   task automatic feed(input logic lane, input logic [8:0] bits, input int n);
      int hi;
      hi = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.gnt === (2'b01 << lane)) hi++;
         bus.x[lane]  = bits[i];
         bus.x[~lane] = ~bits[i];
         step();
      end
      check("gnt_hold", 32'(hi), 32'(n));
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.req          = 2'b00;
      bus.x            = 2'b00;
      bus.result_ready = 1'b0;
      step();
      step();
      step();
      check("rst_gnt",     32'(bus.gnt), 0);
      check("rst_busy",    32'(bus.busy), 0);
      check("rst_rv",      32'(bus.result_valid), 0);
      check("rst_perr",    32'(bus.parity_err), 0);
      check("rst_rsrc",    32'(bus.result_src), 0);
      check("rst_abort",   32'(bus.abort), 0);
      check("rst_err_cnt", 32'(bus.err_cnt), 0);
      rst_n = 1'b1;
      step();
      check("idle_busy", 32'(bus.busy), 0);

      // Reset in the middle of a lane0 frame
      bus.req = 2'b01;
      step();
      check("mid_gnt", 32'(bus.gnt), 1);
      feed(1'b0, 9'h04D, 4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt",   32'(bus.gnt), 0);
      check("mid_rst_busy",  32'(bus.busy), 0);
      check("mid_rst_rv",    32'(bus.result_valid), 0);
      check("mid_rst_abort", 32'(bus.abort), 0);
      step();
      rst_n = 1'b1;
      step();
      check("fresh_gnt", 32'(bus.gnt), 1);
      check("fresh_rv",  32'(bus.result_valid), 0);
      feed(1'b0, 9'h04D, 9);
      check("ok_gnt",     32'(bus.gnt), 0);
      check("ok_rv",      32'(bus.result_valid), 1);
      check("ok_perr",    32'(bus.parity_err), 0);
      check("ok_rsrc",    32'(bus.result_src), 0);
      check("ok_busy",    32'(bus.busy), 1);
      check("ok_err_cnt", 32'(bus.err_cnt), 0);
      bus.req          = 2'b00;
      bus.result_ready = 1'b1;
      step();
      check("ok_hs_rv",      32'(bus.result_valid), 0);
      check("ok_hs_busy",    32'(bus.busy), 0);
      check("ok_hs_err_cnt", 32'(bus.err_cnt), 0);
      bus.result_ready = 1'b0;

      // Wrong parity bit on lane0
      bus.req = 2'b01;
      step();
      check("bad_gnt", 32'(bus.gnt), 1);
      feed(1'b0, 9'h14D, 9);
      bus.req = 2'b00;
      check("bad_rv",   32'(bus.result_valid), 1);
      check("bad_perr", 32'(bus.parity_err), 1);
      check("bad_rsrc", 32'(bus.result_src), 0);
      bus.result_ready = 1'b1;
      step();
      check("bad_err_cnt", 32'(bus.err_cnt), 1);
      check("bad_hs_rv",   32'(bus.result_valid), 0);

      // 256 more error frames with ready held high: count must pin at 255
      for (int i = 0; i < 256; i++) begin
         bus.req = 2'b01;
         step();
         feed(1'b0, 9'h14D, 9);
         bus.req = 2'b00;
         step();
         if (i == 99) check("sat_mid", 32'(bus.err_cnt), 101);
      end
      check("sat_err_cnt", 32'(bus.err_cnt), 255);
      bus.result_ready = 1'b0;

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst2_err_cnt", 32'(bus.err_cnt), 0);
      step();

      // Both lanes requesting: strict alternation starting at lane0
      bus.req          = 2'b11;
      bus.result_ready = 1'b1;
      step();
      check("alt0_gnt", 32'(bus.gnt), 1);
      feed(1'b0, 9'h04D, 9);
      check("alt0_rv",   32'(bus.result_valid), 1);
      check("alt0_rsrc", 32'(bus.result_src), 0);
      check("alt0_perr", 32'(bus.parity_err), 0);
      step();
      check("alt_idle_gnt",  32'(bus.gnt), 0);
      check("alt_idle_busy", 32'(bus.busy), 0);
      check("alt_idle_rv",   32'(bus.result_valid), 0);
      step();
      check("alt1_gnt", 32'(bus.gnt), 2);
      feed(1'b1, 9'h107, 9);
      check("alt1_rsrc", 32'(bus.result_src), 1);
      check("alt1_perr", 32'(bus.parity_err), 0);
      step();
      check("alt1_idle_gnt", 32'(bus.gnt), 0);
      step();
      check("alt2_gnt", 32'(bus.gnt), 1);
      feed(1'b0, 9'h14D, 9);
      check("alt2_rsrc", 32'(bus.result_src), 0);
      check("alt2_perr", 32'(bus.parity_err), 1);
      bus.req = 2'b00;
      step();
      check("alt2_err_cnt", 32'(bus.err_cnt), 1);
      bus.result_ready = 1'b0;

      // Lane1 result held against back-pressure for 5 cycles
      bus.req = 2'b10;
      step();
      check("bp_gnt", 32'(bus.gnt), 2);
      feed(1'b1, 9'h007, 9);
      bus.req = 2'b00;
      for (int i = 0; i < 5; i++) begin
         check("bp_rv",   32'(bus.result_valid), 1);
         check("bp_perr", 32'(bus.parity_err), 1);
         check("bp_rsrc", 32'(bus.result_src), 1);
         check("bp_gnt0", 32'(bus.gnt), 0);
         step();
      end
      bus.result_ready = 1'b1;
      step();
      check("bp_hs_rv",      32'(bus.result_valid), 0);
      check("bp_hs_busy",    32'(bus.busy), 0);
      check("bp_hs_err_cnt", 32'(bus.err_cnt), 2);
      bus.result_ready = 1'b0;

      // Lane0 gives up after 3 bits while lane1 waits
      bus.req = 2'b11;
      step();
      check("ab_gnt", 32'(bus.gnt), 1);
      feed(1'b0, 9'h04D, 3);
      bus.req[0] = 1'b0;
      step();
      check("ab_gnt_drop", 32'(bus.gnt), 0);
      check("ab_pulse",    32'(bus.abort), 1);
      check("ab_rv",       32'(bus.result_valid), 0);
      step();
      check("ab_next_gnt",  32'(bus.gnt), 2);
      check("ab_pulse_end", 32'(bus.abort), 0);
      check("ab_err_cnt",   32'(bus.err_cnt), 2);
      feed(1'b1, 9'h107, 9);
      bus.req = 2'b00;
      check("ab_l1_rv",   32'(bus.result_valid), 1);
      check("ab_l1_rsrc", 32'(bus.result_src), 1);
      check("ab_l1_perr", 32'(bus.parity_err), 0);
      bus.result_ready = 1'b1;
      step();
      check("ab_l1_hs_rv",  32'(bus.result_valid), 0);
      check("ab_l1_err_cnt", 32'(bus.err_cnt), 2);
      bus.result_ready = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
